// File: rtl/div_repsub.sv
// Unsigned repeated-subtraction divider: one subtract per clock, operands
// loaded serially on data_in (dividend with start, divisor on the next cycle).
module div_repsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_B,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divisor;
  logic             rem_ge_div;
  logic [WIDTH-1:0] rem_minus_div;

  // The subtract result is only committed when remainder >= divisor, so it never borrows.
  assign rem_ge_div    = (remainder >= divisor);
  assign rem_minus_div = remainder - divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      divisor     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            remainder   <= data_in;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD_B;
          end
        end
        LOAD_B: begin
          divisor <= data_in;
          if (data_in == '0) begin
            quotient    <= '1;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (rem_ge_div) begin
            remainder <= rem_minus_div;
            quotient  <= quotient + WIDTH'(1);
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_repsub.sv
// Scoreboard bench for div_repsub: stimulus pushes hand-computed results,
// a monitor pops and compares on every rising edge of done.
module tb_div_repsub;

  localparam int WIDTH = 16;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned dz;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic done_q = 1'b0;

  div_repsub #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue start with the dividend, then the divisor on the following cycle.
  task automatic applyStimulus(input int unsigned a, input int unsigned b,
                               input int unsigned q, input int unsigned r,
                               input int unsigned dz, input int lat);
    exp_t e;
    start   = 1'b1;
    data_in = WIDTH'(a);
    @(negedge clk);
    e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.start_cyc = cyc;
    sb.push_back(e);
    checkOutput("done_low_after_start", done, 0);
    checkOutput("busy_after_start", busy, 1);
    start   = 1'b0;
    data_in = WIDTH'(b);
  endtask

  task automatic waitDone(input int limit);
    int   n = 0;
    logic busy_gap = 1'b0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
      if (!done && !busy) busy_gap = 1'b1;
    end
    checkOutput("done_reached", done, 1);
    checkOutput("busy_gap", busy_gap, 0);
    checkOutput("busy_at_done", busy, 0);
  endtask

  // Monitor: compare the oldest expected result whenever done rises.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", div_by_zero, e.dz);
        checkOutput("latency", cyc - e.start_cyc, e.lat);
      end
    end
    done_q = done;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dz", div_by_zero, 0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    // Typical case, A<B, zero dividend, divide-by-zero
    applyStimulus(100, 7, 14, 2, 0, 16);   waitDone(100);
    applyStimulus(5, 9, 0, 5, 0, 2);       waitDone(100);
    applyStimulus(0, 3, 0, 0, 0, 2);       waitDone(100);
    applyStimulus(42, 0, 16'hFFFF, 42, 1, 1); waitDone(100);
    applyStimulus(65535, 65535, 1, 0, 0, 3);  waitDone(100);

    // start pulsed during CALC must be ignored
    applyStimulus(100, 7, 14, 2, 0, 16);
    repeat (3) @(negedge clk);
    start   = 1'b1;
    data_in = 16'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone(100);

    // New op straight from DONE
    applyStimulus(9, 3, 3, 0, 0, 5);       waitDone(100);

    // Synchronous reset in the middle of CALC abandons the operation
    start   = 1'b1;
    data_in = 16'd1000;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'd1;
    repeat (5) @(negedge clk);
    checkOutput("mid_calc_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_dz", div_by_zero, 0);
    checkOutput("mid_rst_quotient", quotient, 0);
    checkOutput("mid_rst_remainder", remainder, 0);
    applyStimulus(20, 6, 3, 2, 0, 5);      waitDone(100);

    // Worst case run length
    applyStimulus(65535, 1, 65535, 0, 0, 65537); waitDone(70000);

    @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
